// File: rtl/agc_seq_pkg.sv
// Shared types and default durations for the AGC power/start sequencer.
package agc_seq_pkg;

  typedef enum logic [2:0] {
    StRstHold  = 3'd0,
    StStrtHold = 3'd1,
    StRun      = 3'd2,
    StStandby  = 3'd3,
    StWake     = 3'd4
  } seq_state_t;

  localparam int unsigned DefRstCycles   = 64;
  localparam int unsigned DefStrt2Cycles = 409600;
  localparam int unsigned DefWakeCycles  = 2048;
  localparam int unsigned DefSbyFilt     = 16;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/level_filter.sv
// Consecutive-sample level filter: hit pulses on the tick that completes FILT
// matching samples in a row.
module level_filter #(
  parameter int unsigned FILT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic en,
  input  logic clr,
  input  logic din,
  input  logic target,
  output logic hit
);

  localparam int unsigned CntW = $clog2(FILT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            match;

  assign match = (din == target);
  // Kept independent of clr: clr is derived from the state change that hit causes.
  assign hit   = tick && en && match && (cnt_q >= CntW'(FILT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && en) begin
      if (!match) begin
        cnt_d = '0;
      end else if (cnt_q != CntW'(FILT)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/agc_power_seq.sv
// AGC power/start sequencer: sequences sim reset, switched +4V, STRT2 and
// standby on B8 ticks, with monitor-driven restart.
module agc_power_seq
  import agc_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = DefRstCycles,
  parameter int unsigned STRT2_CYCLES = DefStrt2Cycles,
  parameter int unsigned WAKE_CYCLES  = DefWakeCycles,
  parameter int unsigned SBY_FILT     = DefSbyFilt
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b8_tick,
  input  logic       sbyrel_n,
  input  logic       force_restart,
  output logic       sim_rst,
  output logic       p4vsw,
  output logic       strt2,
  output logic [2:0] state
);

  localparam int unsigned MaxCycles = max3(RST_CYCLES, STRT2_CYCLES, WAKE_CYCLES);
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  seq_state_t      state_q, state_d;
  logic [CntW-1:0] dur_q, dur_d;
  logic [CntW-1:0] limit;
  logic            timed;
  logic            restart;
  logic            filt_en, filt_clr, filt_hit;
  logic            sim_rst_q, sim_rst_d;
  logic            p4vsw_q, p4vsw_d;
  logic            strt2_q, strt2_d;

  assign filt_en  = (state_q == StRun) || (state_q == StStandby);
  assign restart  = force_restart && (state_q != StRstHold);
  assign filt_clr = (state_d != state_q) || restart;

  level_filter #(
    .FILT (SBY_FILT)
  ) u_sby_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (b8_tick),
    .en     (filt_en),
    .clr    (filt_clr),
    .din    (sbyrel_n),
    .target (state_q == StStandby),
    .hit    (filt_hit)
  );

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    limit   = '0;
    timed   = 1'b0;

    unique case (state_q)
      StRstHold: begin
        limit = CntW'(RST_CYCLES - 1);
        timed = 1'b1;
        if (b8_tick && dur_q == limit) state_d = StStrtHold;
      end
      StStrtHold: begin
        limit = CntW'(STRT2_CYCLES - 1);
        timed = 1'b1;
        if (b8_tick && dur_q == limit) state_d = StRun;
      end
      StRun: begin
        if (filt_hit) state_d = StStandby;
      end
      StStandby: begin
        if (filt_hit) state_d = StWake;
      end
      StWake: begin
        limit = CntW'(WAKE_CYCLES - 1);
        timed = 1'b1;
        if (b8_tick && dur_q == limit) state_d = StRun;
      end
      default: state_d = StRstHold;
    endcase

    if (timed && b8_tick) dur_d = dur_q + CntW'(1);

    // Restart overrides any same-cycle expiry or standby decision.
    if (restart) state_d = StStrtHold;
    if (restart || state_d != state_q) dur_d = '0;
  end

  always_comb begin
    sim_rst_d = (state_d == StRstHold);
    p4vsw_d   = (state_d == StStrtHold) || (state_d == StRun) || (state_d == StWake);
    strt2_d   = (state_d == StRstHold) || (state_d == StStrtHold) || (state_d == StWake);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRstHold;
      dur_q     <= '0;
      sim_rst_q <= 1'b1;
      p4vsw_q   <= 1'b0;
      strt2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      sim_rst_q <= sim_rst_d;
      p4vsw_q   <= p4vsw_d;
      strt2_q   <= strt2_d;
    end
  end

  assign sim_rst = sim_rst_q;
  assign p4vsw   = p4vsw_q;
  assign strt2   = strt2_q;
  assign state   = state_q;

endmodule

// File: tb/tb_agc_power_seq.sv
// Scoreboard bench for agc_power_seq: stimulus queues expected output changes,
// a monitor pops and checks them whenever the outputs change.
module tb_agc_power_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b8_tick = 1'b0;
  logic       sbyrel_n = 1'b1;
  logic       force_restart = 1'b0;
  logic       sim_rst, p4vsw, strt2;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  bit ev_q = 1'b0;

  // out = {state, sim_rst, p4vsw, strt2}
  typedef struct {
    logic [5:0] out;
    int         tick;
    bit         chk;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [5:0] cur;
  logic [5:0] prev = 6'b000101;
  int         base;

  always #5 clk = ~clk;

  agc_power_seq #(
    .RST_CYCLES   (4),
    .STRT2_CYCLES (10),
    .WAKE_CYCLES  (6),
    .SBY_FILT     (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .b8_tick       (b8_tick),
    .sbyrel_n      (sbyrel_n),
    .force_restart (force_restart),
    .sim_rst       (sim_rst),
    .p4vsw         (p4vsw),
    .strt2         (strt2),
    .state         (state)
  );

  // b8_tick: one clk high every 25 clks.
  initial begin
    forever begin
      repeat (24) @(negedge clk);
      b8_tick = 1'b1;
      @(negedge clk);
      b8_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (b8_tick) tick_cnt <= tick_cnt + 1;
    ev_q <= b8_tick | force_restart;
  end

  always @(negedge clk) begin
    cur = {state, sim_rst, p4vsw, strt2};
    if (cur !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %b at tick %0d, nothing expected", cur, tick_cnt);
      end else begin
        e = sb.pop_front();
        if (cur !== e.out || (e.chk && (tick_cnt != e.tick || !ev_q))) begin
          errors++;
          $display("FAIL transition: got %b at tick %0d (edge_evt=%0d), expected %b at tick %0d",
                   cur, tick_cnt, ev_q, e.out, e.tick);
        end
      end
      prev = cur;
    end
  end

  task automatic push(input logic [2:0] st, input logic sr, input logic pv, input logic s2,
                      input int t, input bit chk);
    exp_t x;
    x.out  = {st, sr, pv, s2};
    x.tick = t;
    x.chk  = chk;
    sb.push_back(x);
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = tick_cnt + n;
    while (tick_cnt < t) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {state, sim_rst, p4vsw, strt2}, 6'b000101);

    // 1: power-up sequence
    base = tick_cnt;
    push(3'd1, 1'b0, 1'b1, 1'b1, base + 4, 1'b1);
    push(3'd2, 1'b0, 1'b1, 1'b0, base + 14, 1'b1);
    rst_n = 1'b1;
    wait_ticks(16);
    check("s1_run", {state, sim_rst, p4vsw, strt2}, 6'b010010);

    // 2: standby entry, then wake and back to run
    base = tick_cnt;
    push(3'd3, 1'b0, 1'b0, 1'b0, base + 3, 1'b1);
    sbyrel_n = 1'b0;
    wait_ticks(3);
    base = tick_cnt;
    push(3'd4, 1'b0, 1'b1, 1'b1, base + 3, 1'b1);
    push(3'd2, 1'b0, 1'b1, 1'b0, base + 9, 1'b1);
    sbyrel_n = 1'b1;
    wait_ticks(11);
    check("s2_run", {state, sim_rst, p4vsw, strt2}, 6'b010010);

    // 3: two-tick glitch is filtered out
    sbyrel_n = 1'b0;
    wait_ticks(2);
    sbyrel_n = 1'b1;
    wait_ticks(5);
    check("s3_glitch_run", {state, sim_rst, p4vsw, strt2}, 6'b010010);

    // 4: restart from standby
    base = tick_cnt;
    push(3'd3, 1'b0, 1'b0, 1'b0, base + 3, 1'b1);
    sbyrel_n = 1'b0;
    wait_ticks(4);
    base = tick_cnt;
    push(3'd1, 1'b0, 1'b1, 1'b1, base, 1'b1);
    push(3'd2, 1'b0, 1'b1, 1'b0, base + 10, 1'b1);
    sbyrel_n = 1'b1;
    force_restart = 1'b1;
    @(negedge clk);
    force_restart = 1'b0;
    wait_ticks(12);
    check("s4_run", {state, sim_rst, p4vsw, strt2}, 6'b010010);

    // 5a: restart coincident with the third filter tick wins
    base = tick_cnt;
    sbyrel_n = 1'b0;
    wait_ticks(2);
    @(posedge b8_tick);
    push(3'd1, 1'b0, 1'b1, 1'b1, base + 3, 1'b1);
    push(3'd2, 1'b0, 1'b1, 1'b0, base + 13, 1'b1);
    force_restart = 1'b1;
    @(negedge clk);
    force_restart = 1'b0;
    sbyrel_n = 1'b1;
    wait_ticks(11);
    check("s5a_run", {state, sim_rst, p4vsw, strt2}, 6'b010010);

    // 5b: restart ignored in reset hold
    push(3'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    base = tick_cnt;
    push(3'd1, 1'b0, 1'b1, 1'b1, base + 4, 1'b1);
    push(3'd2, 1'b0, 1'b1, 1'b0, base + 14, 1'b1);
    rst_n = 1'b1;
    wait_ticks(1);
    force_restart = 1'b1;
    @(negedge clk);
    force_restart = 1'b0;
    wait_ticks(14);
    check("s5b_run", {state, sim_rst, p4vsw, strt2}, 6'b010010);

    // 6: asynchronous reset mid-wake
    base = tick_cnt;
    push(3'd3, 1'b0, 1'b0, 1'b0, base + 3, 1'b1);
    sbyrel_n = 1'b0;
    wait_ticks(3);
    base = tick_cnt;
    push(3'd4, 1'b0, 1'b1, 1'b1, base + 3, 1'b1);
    sbyrel_n = 1'b1;
    wait_ticks(5);
    check("s6_in_wake", {state, sim_rst, p4vsw, strt2}, 6'b100011);
    push(3'd0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_async_reset", {state, sim_rst, p4vsw, strt2}, 6'b000101);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change: got no change, expected %b at tick %0d", e.out, e.tick);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
